// File: rtl/dram_burst_reader.sv
// AXI4 burst read engine: splits a (start, nbytes) job into INCR bursts of at most
// BURST_BEATS beats and forwards the returned read data as a ready/valid stream.
module dram_burst_reader #(
    parameter int DATA_W          = 64,
    parameter int BURST_BEATS     = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    output logic [31:0]       M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    input  logic              M_AXI_RLAST,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              CONFIG_VALID,
    output logic              CONFIG_READY,
    input  logic [31:0]       CONFIG_START_ADDR,
    input  logic [31:0]       CONFIG_NBYTES,
    output logic [DATA_W-1:0] DATA,
    output logic              DATA_VALID,
    input  logic              DATA_READY,
    output logic              DATA_LAST,
    output logic              DONE,
    output logic              ERROR,
    output logic              DBG_BUSY
);

    localparam int BPB         = DATA_W / 8;
    localparam int SZ          = $clog2(BPB);
    localparam int CNT_W       = 32 - SZ;
    localparam int BURST_BYTES = BPB * BURST_BEATS;
    localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);

    // Valid/ready rule on every channel: a transfer happens on a rising edge where
    // both valid and ready are high; valid-side payload holds until that edge.

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] addr_rem_q;
    logic [CNT_W-1:0] data_rem_q;
    logic [OUT_W-1:0] outst_q;
    logic             done_q;
    logic             error_q;

    logic [CNT_W-1:0] ar_beats;
    logic             ar_hs;
    logic             r_hs;
    logic             busy;
    logic             unused_lsbs;

    assign busy        = (state_q == BUSY);
    assign unused_lsbs = ^{CONFIG_NBYTES[SZ-1:0], CONFIG_START_ADDR[SZ-1:0]};

    assign ar_beats = (addr_rem_q < CNT_W'(BURST_BEATS)) ? addr_rem_q : CNT_W'(BURST_BEATS);

    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = 8'(ar_beats - CNT_W'(1));
    assign M_AXI_ARSIZE  = 3'(SZ);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = busy && (addr_rem_q != '0) && (outst_q < OUT_W'(MAX_OUTSTANDING));
    assign M_AXI_RREADY  = busy && DATA_READY;

    assign CONFIG_READY = (state_q == IDLE);
    assign DATA         = M_AXI_RDATA;
    assign DATA_VALID   = busy && M_AXI_RVALID;
    assign DATA_LAST    = DATA_VALID && (data_rem_q == CNT_W'(1));
    assign DONE         = done_q;
    assign ERROR        = error_q;
    assign DBG_BUSY     = busy;

    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID && M_AXI_RREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            addr_rem_q <= '0;
            data_rem_q <= '0;
            outst_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (CONFIG_VALID) begin
                        state_q    <= BUSY;
                        addr_q     <= {CONFIG_START_ADDR[31:SZ], {SZ{1'b0}}};
                        addr_rem_q <= CONFIG_NBYTES[31:SZ];
                        data_rem_q <= CONFIG_NBYTES[31:SZ];
                        outst_q    <= '0;
                        error_q    <= 1'b0;
                    end
                end
                BUSY: begin
                    if (ar_hs) begin
                        addr_q     <= addr_q + (32'(ar_beats) << SZ);
                        addr_rem_q <= addr_rem_q - ar_beats;
                    end
                    if (ar_hs && !(r_hs && M_AXI_RLAST)) begin
                        outst_q <= outst_q + 1'b1;
                    end else if (!ar_hs && r_hs && M_AXI_RLAST) begin
                        outst_q <= outst_q - 1'b1;
                    end
                    if (r_hs) begin
                        data_rem_q <= data_rem_q - CNT_W'(1);
                        if (M_AXI_RRESP != 2'b00) begin
                            error_q <= 1'b1;
                        end
                        if (data_rem_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end else if (data_rem_q == '0) begin
                        // Zero-beat job: one BUSY cycle, then DONE together with IDLE.
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // BURST_BYTES alignment of the start address is the caller's contract.
    initial_check_unused : assert property (@(posedge ACLK) BURST_BYTES > 0);

endmodule

// File: tb/tb_dram_burst_reader.sv
// Bench for dram_burst_reader: randomised AXI slave, job-level reference model
// checked every cycle, plus directed jobs with hand-computed expectations.
`timescale 1ns/1ps
module tb_dram_burst_reader;

    localparam int DATA_W = 64;
    localparam int BPB    = 8;
    localparam int BB     = 16;
    localparam int MAXO   = 4;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [31:0]       M_AXI_ARADDR;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [7:0]        M_AXI_ARLEN;
    logic [2:0]        M_AXI_ARSIZE;
    logic [1:0]        M_AXI_ARBURST;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;
    logic              M_AXI_RLAST;
    logic [1:0]        M_AXI_RRESP;
    logic              CONFIG_VALID = 1'b0;
    logic              CONFIG_READY;
    logic [31:0]       CONFIG_START_ADDR = '0;
    logic [31:0]       CONFIG_NBYTES = '0;
    logic [DATA_W-1:0] DATA;
    logic              DATA_VALID;
    logic              DATA_READY;
    logic              DATA_LAST;
    logic              DONE;
    logic              ERROR;
    logic              DBG_BUSY;

    dram_burst_reader #(.DATA_W(DATA_W), .BURST_BEATS(BB), .MAX_OUTSTANDING(MAXO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RRESP(M_AXI_RRESP),
        .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
        .CONFIG_START_ADDR(CONFIG_START_ADDR), .CONFIG_NBYTES(CONFIG_NBYTES),
        .DATA(DATA), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .DATA_LAST(DATA_LAST),
        .DONE(DONE), .ERROR(ERROR), .DBG_BUSY(DBG_BUSY)
    );

    // Clock and reset
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {a ^ 32'h5a5a_c3c3, ~a};
    endfunction

    // Slave knobs
    int ar_pct = 100;
    int rv_pct = 100;
    int dr_pct = 100;
    bit hold_r = 0;
    int err_at = -1;
    bit err_rand = 0;

    // AXI slave: queues accepted bursts, returns beats in order, holds RVALID until taken
    logic [31:0] sq_addr[$];
    int          sq_len[$];
    int          s_beat = 0;
    int          sl_cnt = 0;
    logic        keep;

    initial begin
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0;
        M_AXI_RLAST = 0; M_AXI_RRESP = 2'b00; DATA_READY = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                sq_addr.delete(); sq_len.delete(); s_beat = 0;
            end else begin
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    sq_addr.push_back(M_AXI_ARADDR);
                    sq_len.push_back(int'(M_AXI_ARLEN));
                end
                if (M_AXI_RVALID && M_AXI_RREADY) begin
                    sl_cnt++;
                    if (s_beat == sq_len[0]) begin
                        void'(sq_addr.pop_front()); void'(sq_len.pop_front()); s_beat = 0;
                    end else begin
                        s_beat++;
                    end
                end
            end
            keep = M_AXI_RVALID && !M_AXI_RREADY && !ARESET;
            @(posedge ACLK); #1;
            M_AXI_ARREADY = ($urandom_range(99) < ar_pct);
            DATA_READY    = ($urandom_range(99) < dr_pct);
            if (!keep) begin
                if (sq_len.size() > 0 && !hold_r && $urandom_range(99) < rv_pct) begin
                    M_AXI_RVALID = 1;
                    M_AXI_RDATA  = data_of(sq_addr[0] + 32'(s_beat * BPB));
                    M_AXI_RLAST  = (s_beat == sq_len[0]);
                    M_AXI_RRESP  = (sl_cnt == err_at || (err_rand && $urandom_range(15) == 0)) ? 2'b10 : 2'b00;
                end else begin
                    M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RRESP = 2'b00;
                end
            end
        end
    end

    // Reference model: job-level bookkeeping, compared against DUT every cycle
    logic        m_busy, m_err, m_done, m_arv, m_rhs;
    logic [31:0] m_ar_left, m_data_left, m_addr, m_start;
    int          m_outst, m_idx, nb;
    int          nar, nbeats, ndone, nrdy_low;
    logic [31:0] ar_log_addr[$];
    int          ar_log_len[$];

    initial begin
        m_busy = 0; m_err = 0; m_done = 0; m_ar_left = 0; m_data_left = 0;
        m_addr = 0; m_start = 0; m_outst = 0; m_idx = 0;
        nar = 0; nbeats = 0; ndone = 0; nrdy_low = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                m_busy = 0; m_err = 0; m_done = 0; m_ar_left = 0; m_data_left = 0;
                m_addr = 0; m_outst = 0; m_idx = 0;
            end else begin
                m_arv = m_busy && (m_ar_left != 0) && (m_outst < MAXO);
                m_rhs = m_busy && M_AXI_RVALID && DATA_READY;
                check("config_ready", CONFIG_READY, !m_busy);
                check("dbg_busy", DBG_BUSY, m_busy);
                check("arvalid", M_AXI_ARVALID, m_arv);
                check("arsize", M_AXI_ARSIZE, 3);
                check("arburst", M_AXI_ARBURST, 1);
                if (m_arv) begin
                    check("araddr", M_AXI_ARADDR, m_addr);
                    check("arlen", M_AXI_ARLEN, ((m_ar_left < BB) ? m_ar_left : BB) - 1);
                end
                check("rready", M_AXI_RREADY, m_busy && DATA_READY);
                check("data_valid", DATA_VALID, m_busy && M_AXI_RVALID);
                check("data_pass", DATA, M_AXI_RDATA);
                check("data_last", DATA_LAST, m_busy && M_AXI_RVALID && (m_data_left == 1));
                check("done", DONE, m_done);
                check("error", ERROR, m_err);
                if (m_rhs) check("stream_data", DATA, data_of(m_start + 32'(m_idx * BPB)));
                if (DONE) ndone++;
                if (!CONFIG_READY) nrdy_low++;

                m_done = 0;
                if (CONFIG_VALID && !m_busy) begin
                    m_busy = 1; m_err = 0; m_outst = 0; m_idx = 0;
                    m_ar_left = CONFIG_NBYTES / BPB;
                    m_data_left = m_ar_left;
                    m_addr = CONFIG_START_ADDR & ~32'(BPB - 1);
                    m_start = m_addr;
                end else if (m_busy) begin
                    if (m_arv && M_AXI_ARREADY) begin
                        nb = (m_ar_left < BB) ? int'(m_ar_left) : BB;
                        ar_log_addr.push_back(m_addr);
                        ar_log_len.push_back(nb - 1);
                        nar++;
                        m_addr = m_addr + 32'(nb * BPB);
                        m_ar_left = m_ar_left - 32'(nb);
                        m_outst++;
                    end
                    if (m_rhs) begin
                        if (M_AXI_RLAST) m_outst--;
                        if (M_AXI_RRESP != 2'b00) m_err = 1;
                        m_idx++; nbeats++;
                        m_data_left = m_data_left - 1;
                        if (m_data_left == 0) begin m_busy = 0; m_done = 1; end
                    end else if (m_data_left == 0) begin
                        m_busy = 0; m_done = 1;
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic start_job(input logic [31:0] start, input logic [31:0] nbytes);
        bit acc;
        nar = 0; nbeats = 0; ndone = 0; nrdy_low = 0; sl_cnt = 0;
        ar_log_addr.delete(); ar_log_len.delete();
        @(posedge ACLK); #1;
        CONFIG_VALID = 1; CONFIG_START_ADDR = start; CONFIG_NBYTES = nbytes;
        acc = 0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge ACLK);
            acc = CONFIG_READY;
        end
        check("config_accepted", acc, 1);
        @(posedge ACLK); #1;
        CONFIG_VALID = 0; CONFIG_START_ADDR = $urandom; CONFIG_NBYTES = $urandom;
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge ACLK);
            got = DONE;
        end
        check("done_seen", got, 1);
        @(posedge ACLK); #1;
    endtask

    task automatic pulse_reset();
        @(posedge ACLK); #1; ARESET = 1;
        @(posedge ACLK); #1; ARESET = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge ACLK);
        check({tag, "_cfg_ready"}, CONFIG_READY, 1);
        check({tag, "_arvalid"}, M_AXI_ARVALID, 0);
        check({tag, "_rready"}, M_AXI_RREADY, 0);
        check({tag, "_dvalid"}, DATA_VALID, 0);
        check({tag, "_dlast"}, DATA_LAST, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_error"}, ERROR, 0);
        check({tag, "_araddr"}, M_AXI_ARADDR, 0);
    endtask

    initial begin
        bit reached;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;
        check_reset_outputs("reset");

        // Two full bursts, no stalls
        start_job(32'h1000, 256); wait_done();
        check("j1_nar", nar, 2);
        check("j1_ar0_addr", ar_log_addr[0], 32'h1000);
        check("j1_ar0_len", ar_log_len[0], 15);
        check("j1_ar1_addr", ar_log_addr[1], 32'h1080);
        check("j1_ar1_len", ar_log_len[1], 15);
        check("j1_beats", nbeats, 32);
        check("j1_dones", ndone, 1);

        // Partial last burst
        start_job(32'h0, 200); wait_done();
        check("j2_nar", nar, 2);
        check("j2_ar1_addr", ar_log_addr[1], 32'h80);
        check("j2_ar1_len", ar_log_len[1], 8);
        check("j2_beats", nbeats, 25);
        check("j2_dones", ndone, 1);

        // Sub-beat job: nothing on AXI, one BUSY cycle
        start_job(32'h2000, 7); wait_done();
        check("j3_nar", nar, 0);
        check("j3_beats", nbeats, 0);
        check("j3_dones", ndone, 1);
        check("j3_ready_low", nrdy_low, 1);

        // Outstanding limit with R channel blocked
        hold_r = 1;
        start_job(32'h0, 1024);
        repeat (30) @(posedge ACLK);
        @(negedge ACLK);
        check("j4_nar_capped", nar, MAXO);
        check("j4_arvalid_low", M_AXI_ARVALID, 0);
        hold_r = 0;
        wait_done();
        check("j4_nar", nar, 8);
        check("j4_beats", nbeats, 128);

        // Error response on beat 5, sticky through DONE, cleared by next accept
        err_at = 4;
        start_job(32'h3000, 128); wait_done();
        check("j5_error_held", ERROR, 1);
        err_at = -1;
        start_job(32'h4000, 64); wait_done();
        check("j6_error_clear", ERROR, 0);

        // Address wrap at 4 GB
        start_job(32'hFFFF_FF80, 256); wait_done();
        check("j7_wrap_addr", ar_log_addr[1], 32'h0);

        // Reset mid-job with DATA_READY toggling
        dr_pct = 50;
        start_job(32'h5000, 512);
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge ACLK);
            reached = (nbeats >= 9);
        end
        check("j8_reached_beat10", reached, 1);
        pulse_reset();
        check_reset_outputs("midreset");
        repeat (20) @(posedge ACLK);
        check("j8_no_done", ndone, 0);
        dr_pct = 100;
        start_job(32'h6000, 96); wait_done();
        check("j9_beats", nbeats, 12);
        check("j9_dones", ndone, 1);

        // Randomised jobs
        for (int j = 0; j < 20; j++) begin
            ar_pct = $urandom_range(40, 100);
            rv_pct = $urandom_range(40, 100);
            dr_pct = $urandom_range(40, 100);
            err_rand = ($urandom_range(3) == 0);
            start_job($urandom & 32'hFFFF_FF80, $urandom_range(0, 600));
            wait_done();
            check("rand_dones", ndone, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
